// File: rtl/cipher_dispatch.sv
// Dispatch/collect unit: serialises master words into per-engine symbols and
// merges engine outputs into one buffered stream with sticky error flags.
module cipher_dispatch #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_sys,
  input  logic                         rst_n,
  input  logic [SEL_WIDTH-1:0]         select,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         busy,
  output logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_o,
  output logic [NUM_CH-1:0]            ch_valid_o,
  input  logic [NUM_CH-1:0]            ch_busy_i,
  input  logic [NUM_CH*SYS_DWIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_valid_i,
  output logic [SYS_DWIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  input  logic                         clr_i,
  output logic                         err_sel,
  output logic                         err_collide,
  output logic                         err_ovf
);

  localparam int N    = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW   = $clog2(N + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int SELN = 2 ** SEL_WIDTH;
  localparam int CHW  = NUM_CH * SYS_DWIDTH;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic [MST_DWIDTH-1:0]  sh_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_CH-1:0]      chv_q;
  logic [CHW-1:0]         chd_q;
  logic                   err_sel_q, err_collide_q, err_ovf_q;

  logic [SELN-1:0]        busy_pad;
  logic                   sel_ok;

  assign busy_pad = SELN'(ch_busy_i);
  assign sel_ok   = int'(select) < NUM_CH;

  // cnt_q counts symbols already issued; the first symbol is issued on the
  // accepting edge so symbols occupy cycles T+1..T+N and busy drops at T+N+1.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      sh_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      chv_q   <= '0;
      chd_q   <= '0;
    end else begin
      chv_q <= '0;
      chd_q <= '0;
      case (state_q)
        IDLE: begin
          if (valid_i && sel_ok) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            sel_q   <= select;
            if (!busy_pad[select]) begin
              chv_q <= NUM_CH'(1) << select;
              chd_q <= CHW'(data_i[MST_DWIDTH-1 -: SYS_DWIDTH]) << (int'(select) * SYS_DWIDTH);
              sh_q  <= data_i << SYS_DWIDTH;
              cnt_q <= CW'(1);
            end else begin
              sh_q  <= data_i;
              cnt_q <= '0;
            end
          end
        end
        SHIFT: begin
          if (cnt_q == CW'(N)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!busy_pad[sel_q]) begin
            chv_q <= NUM_CH'(1) << sel_q;
            chd_q <= CHW'(sh_q[MST_DWIDTH-1 -: SYS_DWIDTH]) << (int'(sel_q) * SYS_DWIDTH);
            sh_q  <= sh_q << SYS_DWIDTH;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign ch_valid_o = chv_q;
  assign ch_data_o  = chd_q;

  // Collect: lowest-index valid engine wins.
  logic [SYS_DWIDTH-1:0] push_data;
  logic                  push, collide;

  always_comb begin
    push_data = '0;
    push      = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_valid_i[k] && !push) begin
        push      = 1'b1;
        push_data = ch_data_i[k*SYS_DWIDTH +: SYS_DWIDTH];
      end
    end
  end

  assign collide = |(ch_valid_i & (ch_valid_i - NUM_CH'(1)));

  logic [SYS_DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q, rd_d;
  logic [AW:0]           cnt_f_q, cnt_f_d;
  logic [SYS_DWIDTH-1:0] data_q, head_d;
  logic                  valid_q, full, pop, do_push, ovf_evt, sel_evt;

  assign full    = cnt_f_q == (AW+1)'(FIFO_DEPTH);
  assign pop     = valid_q && ready_i;
  assign do_push = push && (!full || pop);
  assign ovf_evt = push && full && !pop;
  assign sel_evt = (state_q == IDLE) && valid_i && !sel_ok;
  assign rd_d    = pop ? rd_q + 1'b1 : rd_q;

  always_comb begin
    cnt_f_d = cnt_f_q;
    if (do_push && !pop)      cnt_f_d = cnt_f_q + 1'b1;
    else if (pop && !do_push) cnt_f_d = cnt_f_q - 1'b1;
    head_d = (do_push && rd_d == wr_q) ? push_data : mem_q[rd_d];
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_f_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      err_sel_q     <= 1'b0;
      err_collide_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      rd_q          <= rd_d;
      cnt_f_q       <= cnt_f_d;
      valid_q       <= cnt_f_d != '0;
      data_q        <= (cnt_f_d != '0) ? head_d : '0;
      err_sel_q     <= (err_sel_q     & ~clr_i) | sel_evt;
      err_collide_q <= (err_collide_q & ~clr_i) | collide;
      err_ovf_q     <= (err_ovf_q     & ~clr_i) | ovf_evt;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign err_sel     = err_sel_q;
  assign err_collide = err_collide_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cipher_dispatch.sv
// Scoreboard bench for cipher_dispatch: expected engine symbols and FIFO
// output symbols are queued at stimulus time and popped by monitors.
module tb_cipher_dispatch;
  localparam int NCH = 3;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  select = '0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        busy;
  logic [23:0] ch_data_o;
  logic [2:0]  ch_valid_o;
  logic [2:0]  ch_busy_i = '0;
  logic [23:0] ch_data_i = '0;
  logic [2:0]  ch_valid_i = '0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        err_sel, err_collide, err_ovf;

  cipher_dispatch #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .FIFO_DEPTH(8)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
    .busy(busy), .ch_data_o(ch_data_o), .ch_valid_o(ch_valid_o), .ch_busy_i(ch_busy_i),
    .ch_data_i(ch_data_i), .ch_valid_i(ch_valid_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .clr_i(clr_i), .err_sel(err_sel), .err_collide(err_collide),
    .err_ovf(err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] sym;
  } sym_t;

  sym_t       sb[$];
  logic [7:0] fq[$];
  int         errors = 0;
  int         checks = 0;
  int         pops = 0;
  sym_t       exp_sym;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, ch_valid_o, ch_data_o, data_o, valid_o, err_sel, err_collide, err_ovf});
  endfunction

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (ch_valid_o != '0) begin
        if (sb.size() == 0) chk("sym_unexpected", 64'(ch_valid_o), 64'd0);
        else begin
          exp_sym = sb.pop_front();
          chk("sym_valid", 64'(ch_valid_o), 64'(3'b001 << exp_sym.ch));
          chk("sym_data", 64'(ch_data_o), 64'(24'(exp_sym.sym) << (int'(exp_sym.ch) * 8)));
        end
      end
      if (valid_o && ready_i) begin
        pops++;
        if (fq.size() == 0) chk("out_unexpected", 64'(valid_o), 64'd0);
        else chk("out_data", 64'(data_o), 64'(fq.pop_front()));
      end
    end
  end

  // Holds the word on the inputs until the DUT takes it; returns in cycle T+1.
  task automatic drive_word(input logic [1:0] sel, input logic [31:0] w, output int waits);
    logic b;
    logic acc;
    waits = 0;
    acc = 1'b0;
    valid_i = 1'b1;
    select = sel;
    data_i = w;
    if (sel < NCH)
      for (int i = 0; i < 4; i++) sb.push_back(sym_t'{ch: sel, sym: w[31-8*i -: 8]});
    for (int n = 0; n < 50; n++) begin
      b = busy;
      @(posedge clk_sys); #1;
      if (!b) begin
        acc = 1'b1;
        break;
      end
      waits++;
    end
    chk("word_accepted", 64'(acc), 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic count_busy(input int stall_at, input int stall_len, input logic [1:0] sel,
                            output int nb, output int nv);
    nb = 0;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      nb++;
      if (ch_valid_o != '0) nv++;
      ch_busy_i = (i >= stall_at && i < stall_at + stall_len) ? (3'b001 << sel) : 3'b000;
      @(posedge clk_sys); #1;
    end
    ch_busy_i = '0;
  endtask

  task automatic clear_flags();
    clr_i = 1'b1;
    @(posedge clk_sys); #1;
    clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nb, nv, p0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk_sys); #1;
    chk("post_reset_outputs", outs(), 64'd0);

    drive_word(2'd1, 32'h41424344, w);
    chk("t1_wait", 64'(w), 64'd0);
    count_busy(99, 0, 2'd1, nb, nv);
    chk("t1_busy_cycles", 64'(nb), 64'd4);
    chk("t1_sym_cycles", 64'(nv), 64'd4);
    drive_word(2'd1, 32'h55667788, w);
    chk("b2b_wait", 64'(w), 64'd0);
    count_busy(99, 0, 2'd1, nb, nv);
    chk("b2b_busy_cycles", 64'(nb), 64'd4);
    chk("b2b_sym_cycles", 64'(nv), 64'd4);

    drive_word(2'd2, 32'h41424344, w);
    count_busy(1, 3, 2'd2, nb, nv);
    chk("stall_busy_cycles", 64'(nb), 64'd7);
    chk("stall_sym_cycles", 64'(nv), 64'd4);

    drive_word(2'd3, 32'h12345678, w);
    chk("sel_busy", 64'(busy), 64'd0);
    chk("sel_err", 64'(err_sel), 64'd1);
    chk("sel_noissue", 64'(ch_valid_o), 64'd0);
    clear_flags();
    chk("sel_clr", 64'(err_sel), 64'd0);

    ch_data_i = {8'hCC, 8'h00, 8'hAA};
    ch_valid_i = 3'b101;
    fq.push_back(8'hAA);
    @(posedge clk_sys); #1;
    ch_valid_i = '0;
    chk("collide_err", 64'(err_collide), 64'd1);
    chk("collide_valid", 64'(valid_o), 64'd1);
    chk("collide_head", 64'(data_o), 64'hAA);
    clr_i = 1'b1;
    ch_data_i = {8'h00, 8'hBB, 8'h99};
    ch_valid_i = 3'b011;
    fq.push_back(8'h99);
    @(posedge clk_sys); #1;
    clr_i = 1'b0;
    ch_valid_i = '0;
    chk("collide_clr_coincide", 64'(err_collide), 64'd1);
    clear_flags();
    chk("collide_clr", 64'(err_collide), 64'd0);
    ready_i = 1'b1;
    repeat (2) begin @(posedge clk_sys); #1; end
    ready_i = 1'b0;
    chk("collide_drained", 64'(valid_o), 64'd0);

    for (int i = 1; i <= 9; i++) begin
      ch_valid_i = 3'b001;
      ch_data_i = 24'(i);
      if (i <= 8) fq.push_back(8'(i));
      if (i == 9) chk("ovf_at_full", 64'(err_ovf), 64'd0);
      @(posedge clk_sys); #1;
    end
    ch_valid_i = '0;
    chk("ovf_err", 64'(err_ovf), 64'd1);
    chk("ovf_valid", 64'(valid_o), 64'd1);
    chk("ovf_head", 64'(data_o), 64'h01);
    clear_flags();
    chk("ovf_clr", 64'(err_ovf), 64'd0);

    ready_i = 1'b1;
    ch_valid_i = 3'b001;
    ch_data_i = 24'h00000A;
    fq.push_back(8'h0A);
    @(posedge clk_sys); #1;
    ready_i = 1'b0;
    chk("full_pushpop_ovf", 64'(err_ovf), 64'd0);
    ch_data_i = 24'h00000B;
    @(posedge clk_sys); #1;
    ch_valid_i = '0;
    chk("still_full_ovf", 64'(err_ovf), 64'd1);
    clear_flags();
    p0 = pops;
    ready_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_sys); #1;
      if (!valid_o) break;
    end
    ready_i = 1'b0;
    chk("drain_pops", 64'(pops - p0), 64'd8);
    chk("drain_empty", 64'(valid_o), 64'd0);

    ch_valid_i = 3'b010;
    ch_data_i = 24'h007700;
    fq.push_back(8'h77);
    drive_word(2'd0, 32'hDEADBEEF, w);
    ch_valid_i = '0;
    @(posedge clk_sys); #1;
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), 64'd0);
    sb.delete();
    fq.delete();
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (ch_valid_o != '0) nv++;
    end
    chk("rst_noissue", 64'(nv), 64'd0);
    chk("rst_idle", 64'(busy), 64'd0);

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    chk("fq_leftover", 64'(fq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
